add_tree_pipe: RTL and testbench
================================

// Module: add_tree_pipe
// PURPOSE
//  - Pipelined signed adder tree. Sums NUM_IN signed W-bit operands to full precision.
//  - Successor to the two-operand combinational adder: parametrised operand count, registered tree levels, valid/ready flow control.
//  - Sits between streaming datapath stages, e.g. FIR tap summation and channel combining.
// PARAMETERS
//  - W       8  width of each signed input operand
//  - NUM_IN  4  number of operands, >=1; padded internally with zeros to the next power of two
//  - OW      W+clog2(NUM_IN)  output width, derived (localparam); never overflows
//  - LAT     max(1,clog2(NUM_IN))  pipeline depth in cycles, derived (localparam)
// PORTS
//  - clk        in   1         clock, rising edge
//  - rst        in   1         synchronous reset, active-high
//  - in_valid   in   1         operand vector valid
//  - in_ready   out  1         block accepts operands this cycle
//  - in_data    in   NUM_IN*W  operand i at [i*W +: W], two's complement
//  - out_valid  out  1         sum valid
//  - out_ready  in   1         downstream accepts sum
//  - out_sum    out  OW        signed full-precision sum
//  - out_ovf    out  1         saturation flag; present only with ADD_TREE_SAT_EN
// BEHAVIOUR
//  - Reset: all stage valid bits = 0; out_valid = 0; out_sum = 0; out_ovf = 0. Data registers are cleared too.
//  - Transfer rules:
//    - Input transfer when in_valid & in_ready.
//    - Output transfer when out_valid & out_ready.
//  - Tree: level k adds pairs from level k-1. Each level is sign-extended by 1 bit and registered once.
//    - NUM_IN=1: a single register stage, out_sum = sign-extended in_data.
//  - Latency: an accepted vector appears on out_sum exactly LAT cycles later when there is no backpressure.
//  - Throughput: 1 vector/cycle while out_ready = 1.
//  - Per-stage flow control with bubble collapse:
//    - Stage k loads when its valid = 0 or stage k+1 loads/out transfers.
//    - in_ready = stage-0 load condition. It is combinational from out_ready through the chain.
//  - out_ready = 0 with out_valid = 1: out_sum is held stable. Upstream stages keep filling bubbles, then in_ready drops.
//  - Simultaneous output transfer and input acceptance on a full pipe: both occur with no lost or duplicated vector.
//  - in_data is sampled only on an input transfer. The value while in_valid = 0 is don't-care.
//  - Reset mid-operation: all in-flight vectors are discarded. out_valid = 0 on the cycle after rst is sampled high.
//  - Arithmetic is exact two's complement. out_sum range is [NUM_IN*-2^(W-1), NUM_IN*(2^(W-1)-1)].
// CONFIGURATION
//  - ADD_TREE_SAT_EN undefined:
//    - out_sum is the full-precision sum.
//    - out_ovf port is absent.
//  - ADD_TREE_SAT_EN defined:
//    - The final stage clamps the sum to the signed W-bit range [-2^(W-1), 2^(W-1)-1].
//    - The clamped result is sign-extended onto the unchanged OW-bit out_sum.
//    - out_ovf = 1 with the same timing as out_sum when clamping occurred.
//    - No added latency.
// STRUCTURE
//  - Package add_pkg:
//    - clog2 function
//    - tree-depth/width helper functions: level width W+k, padded count 2^LAT
//    - shared valid/ready stage-control macro
//  - Sub-module add_tree_stage:
//    - One registered tree level: N/2 pairwise signed adds.
//    - Holds the valid bit and the load/ready logic.
//    - Instantiated LAT times via generate.
// TESTING (W=8, NUM_IN=4, LAT=2 unless noted)
//  - Max positive: in_data = {127,127,127,127}, out_ready = 1.
//    -> out_valid = 1 after 2 cycles, out_sum = 508.
//  - Max negative: {-128,-128,-128,-128} -> out_sum = -512.
//  - Mixed: {5,-3,100,-128} -> out_sum = -26.
//  - Odd count: NUM_IN=3, {-1,-1,-1} -> out_sum = -3, LAT = 2.
//  - Streaming: vectors with sums 1..10 on back-to-back cycles, out_ready = 1.
//    -> 10 consecutive outputs in order.
//  - Backpressure: out_ready = 0 for 5 cycles while streaming.
//    -> out_sum held stable; in_ready = 0 once the 2 stages are full.
//    -> no loss or duplicates after release.
//  - Reset: assert rst with 2 vectors in flight.
//    -> out_valid = 0 the next cycle, and neither vector emerges.
//  - ADD_TREE_SAT_EN: {127,127,0,0} -> out_sum = 127, out_ovf = 1.
//    -> {-128,-1,0,0} -> out_sum = -128, out_ovf = 1.
//    -> {10,20,0,0} -> out_sum = 30, out_ovf = 0.

Source files
------------

// File: rtl/add_pkg.sv
// Shared helpers for the pipelined adder tree: depth/width functions and the
// per-stage valid/ready load rule used by every tree level.
`ifndef ADD_PKG_SV
`define ADD_PKG_SV

// A stage may load when it is empty or its current contents move on this cycle.
`define ADD_STAGE_LOAD(vld, dn_rdy) (!(vld) || (dn_rdy))

package add_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v * 2) r = r + 1;
    return r;
  endfunction

  function automatic int tree_lat(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  function automatic int pad_count(input int n);
    return 1 << tree_lat(n);
  endfunction

  function automatic int lvl_width(input int w, input int k);
    return w + k;
  endfunction

  function automatic int lvl_count(input int n, input int k);
    return pad_count(n) >> k;
  endfunction

endpackage

`endif

// File: rtl/add_tree_stage.sv
// One registered adder-tree level: N_IN/2 pairwise signed adds, each result one
// bit wider than its operands, with its own valid bit and load/ready logic.
module add_tree_stage
  import add_pkg::*;
#(
  parameter int W_IN = 8,
  parameter int N_IN = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_valid,
  output logic                             o_ready,
  input  logic [N_IN*W_IN-1:0]             i_data,
  output logic                             o_valid,
  input  logic                             i_ready,
  output logic [(N_IN/2)*(W_IN+1)-1:0]     o_data
);

  localparam int N_OUT = N_IN / 2;
  localparam int W_OUT = W_IN + 1;

  logic                   w_load;
  logic                   r_valid;
  logic [N_OUT*W_OUT-1:0] w_sum;
  logic [N_OUT*W_OUT-1:0] r_data;

  assign w_load = `ADD_STAGE_LOAD(r_valid, i_ready);

  for (genvar j = 0; j < N_OUT; j++) begin : g_pair
    logic signed [W_IN-1:0] w_a;
    logic signed [W_IN-1:0] w_b;
    assign w_a = i_data[(2*j)*W_IN +: W_IN];
    assign w_b = i_data[(2*j+1)*W_IN +: W_IN];
    assign w_sum[j*W_OUT +: W_OUT] = W_OUT'(w_a) + W_OUT'(w_b);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      if (w_load) r_valid <= i_valid;
      if (w_load && i_valid) r_data <= w_sum;
    end
  end

  assign o_ready = w_load;
  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/add_tree_pipe.sv
// Pipelined signed adder tree with valid/ready flow control and bubble collapse.
// Optional macro ADD_TREE_SAT_EN clamps the sum to W bits and adds out_ovf.
module add_tree_pipe
  import add_pkg::*;
#(
  parameter  int W      = 8,
  parameter  int NUM_IN = 4,
  localparam int OW     = W + clog2(NUM_IN),
  localparam int LAT    = tree_lat(NUM_IN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NUM_IN*W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OW-1:0]     out_sum
`ifdef ADD_TREE_SAT_EN
  ,
  output logic              out_ovf
`endif
);

  localparam int P  = pad_count(NUM_IN);
  localparam int FW = lvl_width(W, LAT);

  logic [P*W-1:0] w_pad;
  logic [LAT:0]   w_valid;
  logic [LAT:0]   w_ready;
  logic [FW-1:0]  w_final;

  always_comb begin
    w_pad = '0;
    w_pad[NUM_IN*W-1:0] = in_data;
  end

  assign w_valid[0]   = in_valid;
  assign in_ready     = w_ready[0];
  assign w_ready[LAT] = out_ready;
  assign out_valid    = w_valid[LAT];

  for (genvar k = 0; k < LAT; k++) begin : g_lvl
    localparam int WI = lvl_width(W, k);
    localparam int NI = lvl_count(NUM_IN, k);
    logic [NI*WI-1:0]         w_in;
    logic [(NI/2)*(WI+1)-1:0] w_out;

    if (k == 0) begin : g_src
      assign w_in = w_pad;
    end else begin : g_src
      assign w_in = g_lvl[k-1].w_out;
    end

    add_tree_stage #(.W_IN(WI), .N_IN(NI)) u_stage (
      .clk     (clk),
      .rst     (rst),
      .i_valid (w_valid[k]),
      .o_ready (w_ready[k]),
      .i_data  (w_in),
      .o_valid (w_valid[k+1]),
      .i_ready (w_ready[k+1]),
      .o_data  (w_out)
    );
  end

  assign w_final = g_lvl[LAT-1].w_out;

`ifdef ADD_TREE_SAT_EN
  // Clamp is combinational on the last register, so no latency is added.
  localparam logic signed [FW-1:0] SAT_MAX = FW'((2 ** (W - 1)) - 1);
  localparam logic signed [FW-1:0] SAT_MIN = ~SAT_MAX;

  logic signed [W-1:0] w_clamp;
  logic                w_ovf;

  always_comb begin
    w_clamp = w_final[W-1:0];
    w_ovf   = 1'b0;
    if ($signed(w_final) > SAT_MAX) begin
      w_clamp = {1'b0, {(W-1){1'b1}}};
      w_ovf   = 1'b1;
    end else if ($signed(w_final) < SAT_MIN) begin
      w_clamp = {1'b1, {(W-1){1'b0}}};
      w_ovf   = 1'b1;
    end
  end

  assign out_sum = OW'(w_clamp);
  assign out_ovf = w_ovf;
`else
  assign out_sum = w_final[OW-1:0];
`endif

endmodule

// File: tb/tb_add_tree_pipe.sv
// Self-checking bench for add_tree_pipe: a 4-operand instance and a 3-operand
// instance, checked against a plain-arithmetic sum model and an occupancy queue.
module tb_add_tree_pipe;
  localparam int W   = 8;
  localparam int N   = 4;
  localparam int OW  = 10;
  localparam int LAT = 2;
  localparam int N3  = 3;
  localparam int OW3 = 10;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready, out_valid, out_ready;
  logic [N*W-1:0] in_data;
  logic [OW-1:0]  out_sum;
  logic in3_valid, in3_ready, out3_valid, out3_ready;
  logic [N3*W-1:0] in3_data;
  logic [OW3-1:0]  out3_sum;
`ifdef ADD_TREE_SAT_EN
  logic out_ovf, out3_ovf;
`endif

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  add_tree_pipe #(.W(W), .NUM_IN(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum)
`ifdef ADD_TREE_SAT_EN
    , .out_ovf(out_ovf)
`endif
  );

  add_tree_pipe #(.W(W), .NUM_IN(N3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in3_valid), .in_ready(in3_ready), .in_data(in3_data),
    .out_valid(out3_valid), .out_ready(out3_ready), .out_sum(out3_sum)
`ifdef ADD_TREE_SAT_EN
    , .out_ovf(out3_ovf)
`endif
  );

  function automatic logic [N*W-1:0] pack4(input int a0, input int a1, input int a2, input int a3);
    return {8'(a3), 8'(a2), 8'(a1), 8'(a0)};
  endfunction

  function automatic logic [N3*W-1:0] pack3(input int a0, input int a1, input int a2);
    return {8'(a2), 8'(a1), 8'(a0)};
  endfunction

  // Reference: exact integer sum of the signed operands, clamped when saturating.
  function automatic int ref_sum(input logic [N*W-1:0] v);
    int s;
    s = 0;
    for (int i = 0; i < N; i++) s += int'($signed(v[i*W +: W]));
`ifdef ADD_TREE_SAT_EN
    if (s > 127) s = 127;
    else if (s < -128) s = -128;
`endif
    return s;
  endfunction

  task automatic test_reset();
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b want=0", out_valid);
    else n_pass++;
    n_total++;
    if (out_sum !== '0) $display("FAIL reset_out_sum got=%0d want=0", $signed(out_sum));
    else n_pass++;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b want=1", in_ready);
    else n_pass++;
    n_total++;
    if (out3_valid !== 1'b0) $display("FAIL reset_out3_valid got=%b want=0", out3_valid);
    else n_pass++;
  endtask

  task automatic test_directed();
    logic [N*W-1:0] vecs[3];
    int exp_s[3];
    int lat;
    vecs[0] = pack4(127, 127, 127, 127);
    vecs[1] = pack4(-128, -128, -128, -128);
    vecs[2] = pack4(5, -3, 100, -128);
`ifdef ADD_TREE_SAT_EN
    exp_s = '{127, -128, -26};
`else
    exp_s = '{508, -512, -26};
`endif
    out_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      in_valid = 1'b1;
      in_data  = vecs[t];
      lat = 0;
      do begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = $urandom;
        lat++;
      end while (out_valid !== 1'b1 && lat < 10);
      n_total++;
      if (lat != LAT) $display("FAIL directed_latency[%0d] got=%0d want=%0d", t, lat, LAT);
      else n_pass++;
      n_total++;
      if (out_sum !== OW'(exp_s[t]))
        $display("FAIL directed_sum[%0d] got=%0d want=%0d", t, $signed(out_sum), exp_s[t]);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_odd_count();
    logic [N3*W-1:0] vecs[2];
    int exp_s[2];
    int lat;
    vecs[0] = pack3(-1, -1, -1);
    vecs[1] = pack3(127, 127, 127);
`ifdef ADD_TREE_SAT_EN
    exp_s = '{-3, 127};
`else
    exp_s = '{-3, 381};
`endif
    out3_ready = 1'b1;
    for (int t = 0; t < 2; t++) begin
      in3_valid = 1'b1;
      in3_data  = vecs[t];
      lat = 0;
      do begin
        @(posedge clk); #1;
        in3_valid = 1'b0;
        in3_data  = 24'($urandom);
        lat++;
      end while (out3_valid !== 1'b1 && lat < 10);
      n_total++;
      if (lat != LAT) $display("FAIL odd_latency[%0d] got=%0d want=%0d", t, lat, LAT);
      else n_pass++;
      n_total++;
      if (out3_sum !== OW3'(exp_s[t]))
        $display("FAIL odd_sum[%0d] got=%0d want=%0d", t, $signed(out3_sum), exp_s[t]);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stream();
    logic [N*W-1:0] v[10];
    int a, b, c;
    for (int i = 0; i < 10; i++) begin
      a = int'($urandom_range(60)) - 30;
      b = int'($urandom_range(60)) - 30;
      c = int'($urandom_range(60)) - 30;
      v[i] = pack4(a, b, c, (i + 1) - a - b - c);
    end
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (cyc < 10) begin
        in_valid = 1'b1;
        in_data  = v[cyc];
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (cyc >= 2) begin
        n_total++;
        if (out_valid !== 1'b1) $display("FAIL stream_valid[%0d] got=%b want=1", cyc, out_valid);
        else n_pass++;
        n_total++;
        if (out_sum !== OW'(cyc - 1))
          $display("FAIL stream_sum[%0d] got=%0d want=%0d", cyc, $signed(out_sum), cyc - 1);
        else n_pass++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    int q[$];
    int sent, got, want;
    bit saw_full, stalled_prev, stall;
    logic [OW-1:0] held;
    logic [N*W-1:0] vec;
    logic exp_rdy;
    sent = 0; got = 0; saw_full = 0; stalled_prev = 0; held = '0;
    for (int cyc = 0; cyc < 80 && got < 16; cyc++) begin
      stall     = (cyc >= 4 && cyc < 9);
      out_ready = !stall;
      in_valid  = (sent < 16) && (stall || $urandom_range(3) != 0);
      vec       = $urandom;
      in_data   = vec;
      @(negedge clk);
      exp_rdy = !(q.size() == LAT && !out_ready);
      n_total++;
      if (in_ready !== exp_rdy) $display("FAIL bp_in_ready[%0d] got=%b want=%b", cyc, in_ready, exp_rdy);
      else n_pass++;
      if (in_ready === 1'b0) saw_full = 1;
      if (out_valid === 1'b1 && stalled_prev) begin
        n_total++;
        if (out_sum !== held) $display("FAIL bp_hold[%0d] got=%0d want=%0d", cyc, $signed(out_sum), $signed(held));
        else n_pass++;
      end
      if (out_valid === 1'b1 && out_ready) begin
        want = (q.size() > 0) ? q[0] : 9999;
        n_total++;
        if (q.size() == 0 || out_sum !== OW'(want))
          $display("FAIL bp_sum[%0d] got=%0d want=%0d", cyc, $signed(out_sum), want);
        else n_pass++;
        if (q.size() > 0) void'(q.pop_front());
        got++;
      end
      stalled_prev = (out_valid === 1'b1) && !out_ready;
      held = out_sum;
      if (in_valid && in_ready === 1'b1) begin
        q.push_back(ref_sum(vec));
        sent++;
      end
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n_total++;
    if (got != 16) $display("FAIL bp_count got=%0d want=16", got);
    else n_pass++;
    n_total++;
    if (q.size() != 0) $display("FAIL bp_leftover got=%0d want=0", q.size());
    else n_pass++;
    n_total++;
    if (!saw_full) $display("FAIL bp_saw_full got=0 want=1");
    else n_pass++;
  endtask

  task automatic test_reset_flight();
    int seen;
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data  = pack4(11 + i, 22, 33, 44);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n_total++;
    if (out_valid !== 1'b1) $display("FAIL rstfl_pre_valid got=%b want=1", out_valid);
    else n_pass++;
    rst = 1'b1;
    @(posedge clk); #1;
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL rstfl_valid got=%b want=0", out_valid);
    else n_pass++;
    n_total++;
    if (out_sum !== '0) $display("FAIL rstfl_sum got=%0d want=0", $signed(out_sum));
    else n_pass++;
    rst = 1'b0;
    out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) seen++;
    end
    n_total++;
    if (seen != 0) $display("FAIL rstfl_emerged got=%0d want=0", seen);
    else n_pass++;
  endtask

`ifdef ADD_TREE_SAT_EN
  task automatic test_sat();
    logic [N*W-1:0] vecs[3];
    int exp_s[3];
    logic exp_o[3];
    int lat;
    vecs[0] = pack4(127, 127, 0, 0);
    vecs[1] = pack4(-128, -1, 0, 0);
    vecs[2] = pack4(10, 20, 0, 0);
    exp_s = '{127, -128, 30};
    exp_o = '{1'b1, 1'b1, 1'b0};
    out_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      in_valid = 1'b1;
      in_data  = vecs[t];
      lat = 0;
      do begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat++;
      end while (out_valid !== 1'b1 && lat < 10);
      n_total++;
      if (out_sum !== OW'(exp_s[t]))
        $display("FAIL sat_sum[%0d] got=%0d want=%0d", t, $signed(out_sum), exp_s[t]);
      else n_pass++;
      n_total++;
      if (out_ovf !== exp_o[t]) $display("FAIL sat_ovf[%0d] got=%b want=%b", t, out_ovf, exp_o[t]);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;  in_data = '0;  out_ready = 1'b0;
    in3_valid = 1'b0; in3_data = '0; out3_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_directed();
    test_odd_count();
    test_stream();
    test_backpressure();
    test_reset_flight();
`ifdef ADD_TREE_SAT_EN
    test_sat();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
